// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg -- shared types and helpers for the conversion sequencer.
//   conv_seq_state_t : sequencer state encoding
//   idx_width()      : index width for a given item count (minimum 1 bit)
package conv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_READ,
        S_LOAD,
        S_COUNT,
        S_STORE,
        S_WRITE,
        S_FIN
    } conv_seq_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if -- control bundle between the conversion sequencer and
// the datapath / requester.
//   start, cnt_done                     : requester/datapath -> sequencer
//   read_data, ldn, en_c, store_num,
//   write_to_file                       : sequencer -> datapath strobes
//   item_idx, busy, done, error         : sequencer status
// Modports: master = sequencer side, slave = datapath/requester side.
interface conv_sequencer_if
    import conv_seq_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 8
);

    localparam int unsigned IDX_W = idx_width(NUM_ITEMS);

    logic             start;
    logic             cnt_done;
    logic             read_data;
    logic             ldn;
    logic             en_c;
    logic             store_num;
    logic             write_to_file;
    logic [IDX_W-1:0] item_idx;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  start, cnt_done,
        output read_data, ldn, en_c, store_num, write_to_file,
        output item_idx, busy, done, error
    );

    modport slave (
        output start, cnt_done,
        input  read_data, ldn, en_c, store_num, write_to_file,
        input  item_idx, busy, done, error
    );

endinterface

// File: rtl/conv_seq_watchdog.sv
// conv_seq_watchdog -- count-phase timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart the count (asserted the cycle before COUNT entry)
//   en       : count this cycle (asserted while in COUNT)
//   expired  : MAX_CYCLES enabled cycles have elapsed, this one included
// Only built when CONV_SEQ_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef CONV_SEQ_TIMEOUT_EN
module conv_seq_watchdog
    import conv_seq_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = idx_width(MAX_CYCLES);

    logic [CW-1:0] cnt;

    // Combinational so the FSM can leave COUNT on the MAX_CYCLES-th cycle.
    assign expired = en && (cnt == CW'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/conv_sequencer.sv
// conv_sequencer -- control FSM for the number-conversion datapath.
// On an accepted start pulse (high then low) it walks NUM_ITEMS words through
// READ -> LOAD -> COUNT -> STORE -> WRITE, then pulses done from FIN.
//   clk, rst : clock, synchronous active-high reset
//   bus      : conv_sequencer_if.master (start/cnt_done in, strobes and
//              item_idx/busy/done/error out)
// Option: CONV_SEQ_TIMEOUT_EN adds a COUNT-phase watchdog of MAX_CYCLES cycles;
// on expiry error is set and the batch is abandoned through FIN. Without it
// COUNT waits indefinitely and error is tied low.
module conv_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned NUM_ITEMS  = 8,
    parameter int unsigned MAX_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    conv_sequencer_if.master bus
);

    localparam int unsigned    IDX_W    = idx_width(NUM_ITEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

    if (NUM_ITEMS < 1 || MAX_CYCLES < 1) begin : g_param_check
        $error("conv_sequencer: NUM_ITEMS and MAX_CYCLES must be >= 1");
    end

    conv_seq_state_t  state;
    logic [IDX_W-1:0] idx_q;
    logic             read_q;
    logic             ldn_q;
    logic             store_q;
    logic             write_q;
    logic             busy_q;
    logic             done_q;

`ifdef CONV_SEQ_TIMEOUT_EN
    logic error_q;
    logic timeout;

    conv_seq_watchdog #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_LOAD),
        .en      (state == S_COUNT),
        .expired (timeout)
    );

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    // Moore strobes are registered with the state they belong to, so each
    // output register is loaded on the transition into its state.
    assign bus.read_data     = read_q;
    assign bus.ldn           = ldn_q;
    assign bus.store_num     = store_q;
    assign bus.write_to_file = write_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.item_idx      = idx_q;

    // Counter enable is the only Mealy output: low on the cycle cnt_done arrives.
    assign bus.en_c = (state == S_COUNT) && !bus.cnt_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx_q   <= '0;
            read_q  <= 1'b0;
            ldn_q   <= 1'b0;
            store_q <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CONV_SEQ_TIMEOUT_EN
            error_q <= 1'b0;
`endif
        end else begin
            read_q  <= 1'b0;
            ldn_q   <= 1'b0;
            store_q <= 1'b0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (!bus.start) begin
                        state  <= S_READ;
                        idx_q  <= '0;
                        read_q <= 1'b1;
                        busy_q <= 1'b1;
`ifdef CONV_SEQ_TIMEOUT_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                S_READ: begin
                    state  <= S_LOAD;
                    ldn_q  <= 1'b1;
                    busy_q <= 1'b1;
                end
                S_LOAD: begin
                    state  <= S_COUNT;
                    busy_q <= 1'b1;
                end
                S_COUNT: begin
                    if (bus.cnt_done) begin
                        state   <= S_STORE;
                        store_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
`ifdef CONV_SEQ_TIMEOUT_EN
                    else if (timeout) begin
                        // Abandon the rest of the batch; done still pulses.
                        state   <= S_FIN;
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
`endif
                    else begin
                        busy_q <= 1'b1;
                    end
                end
                S_STORE: begin
                    state   <= S_WRITE;
                    write_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                S_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state  <= S_FIN;
                        done_q <= 1'b1;
                    end else begin
                        state  <= S_READ;
                        idx_q  <= idx_q + IDX_W'(1);
                        read_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer -- directed bench for conv_sequencer.
// u_dut0: NUM_ITEMS=2, MAX_CYCLES=4; u_dut1: NUM_ITEMS=1.
// With CONV_SEQ_TIMEOUT_EN defined the timeout scenario runs; otherwise an
// extended cnt_done stall is exercised instead.
module tb_conv_sequencer;

    // Output vector packing: {read_data, ldn, en_c, store_num, write_to_file, busy, done, error}
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_READ  = 8'b1000_0100;
    localparam logic [7:0] O_LOAD  = 8'b0100_0100;
    localparam logic [7:0] O_CEN   = 8'b0010_0100;
    localparam logic [7:0] O_CNT   = 8'b0000_0100;
    localparam logic [7:0] O_STORE = 8'b0001_0100;
    localparam logic [7:0] O_WRITE = 8'b0000_1100;
    localparam logic [7:0] O_FIN   = 8'b0000_0010;
    localparam logic [7:0] O_ERR   = 8'b0000_0001;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    conv_sequencer_if #(.NUM_ITEMS(2)) b0 ();
    conv_sequencer_if #(.NUM_ITEMS(1)) b1 ();

    conv_sequencer #(
        .NUM_ITEMS  (2),
        .MAX_CYCLES (4)
    ) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    conv_sequencer #(
        .NUM_ITEMS  (1),
        .MAX_CYCLES (32)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive this cycle's inputs just after the edge, then
    // compare the outputs of the state entered at that edge.
    task automatic step(input int sel, input logic r, input logic s, input logic cd,
                        input logic [7:0] exp, input int unsigned exp_idx, input string tag);
        logic [7:0]  got;
        logic [31:0] gidx;
        @(posedge clk);
        #1;
        rst = r;
        if (sel == 0) begin
            b0.start = s;
            b0.cnt_done = cd;
        end else begin
            b1.start = s;
            b1.cnt_done = cd;
        end
        #1;
        if (sel == 0) begin
            got  = {b0.read_data, b0.ldn, b0.en_c, b0.store_num, b0.write_to_file,
                    b0.busy, b0.done, b0.error};
            gidx = 32'(b0.item_idx);
        end else begin
            got  = {b1.read_data, b1.ldn, b1.en_c, b1.store_num, b1.write_to_file,
                    b1.busy, b1.done, b1.error};
            gidx = 32'(b1.item_idx);
        end
        check({tag, "/out"}, 32'(got), 32'(exp));
        check({tag, "/idx"}, gidx, exp_idx);
    endtask

    // IDLE with start high, 'held'-1 more ARMED cycles high, then release.
    task automatic start_batch(input int sel, input int unsigned held, input int unsigned idx_before,
                               input logic [7:0] idle_out, input string tag);
        step(sel, 1'b0, 1'b1, 1'b0, idle_out, idx_before, {tag, "/idle"});
        for (int unsigned i = 1; i < held; i++)
            step(sel, 1'b0, 1'b1, 1'b0, idle_out, idx_before, {tag, "/armed"});
        step(sel, 1'b0, 1'b0, 1'b0, idle_out, idx_before, {tag, "/release"});
    endtask

    // One word with K COUNT cycles (cnt_done on the K-th).
    task automatic word(input int sel, input int unsigned w, input int unsigned k,
                        input logic s_load, input logic noise, input string tag);
        step(sel, 1'b0, 1'b0, noise, O_READ, w, {tag, "/read"});
        step(sel, 1'b0, s_load, 1'b0, O_LOAD, w, {tag, "/load"});
        for (int unsigned c = 1; c < k; c++)
            step(sel, 1'b0, 1'b0, 1'b0, O_CEN, w, {tag, "/cnt_en"});
        step(sel, 1'b0, 1'b0, 1'b1, O_CNT, w, {tag, "/cnt_done"});
        step(sel, 1'b0, 1'b0, noise, O_STORE, w, {tag, "/store"});
        step(sel, 1'b0, 1'b0, noise, O_WRITE, w, {tag, "/write"});
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        b0.start    = 1'b1;
        b0.cnt_done = 1'b0;
        b1.start    = 1'b0;
        b1.cnt_done = 1'b0;

        // Reset held three edges with start high, then start low: nothing moves.
        @(posedge clk);
        step(0, 1'b1, 1'b1, 1'b0, O_NONE, 0, "rst_hold");
        step(0, 1'b1, 1'b1, 1'b0, O_NONE, 0, "rst_hold");
        for (int i = 0; i < 3; i++)
            step(0, 1'b0, 1'b0, 1'b0, O_NONE, 0, "rst_quiet");

        // Two words, start held 5 cycles, K=3, cnt_done noise outside COUNT.
        start_batch(0, 5, 0, O_NONE, "k3");
        word(0, 0, 3, 1'b0, 1'b1, "k3_w0");
        word(0, 1, 3, 1'b0, 1'b1, "k3_w1");
        step(0, 1'b0, 1'b0, 1'b0, O_FIN, 1, "k3_fin");
        step(0, 1'b0, 1'b0, 1'b0, O_NONE, 1, "k3_hold_idx");

        // K=1 with a start pulse during LOAD and another during FIN: both ignored.
        start_batch(0, 1, 1, O_NONE, "k1");
        word(0, 0, 1, 1'b1, 1'b0, "k1_w0");
        word(0, 1, 1, 1'b0, 1'b0, "k1_w1");
        step(0, 1'b0, 1'b1, 1'b0, O_FIN, 1, "k1_fin");
        for (int i = 0; i < 3; i++)
            step(0, 1'b0, 1'b0, 1'b0, O_NONE, 1, "k1_no_queue");

        // Reset during the second word's COUNT, then a fresh K=2 batch.
        start_batch(0, 1, 1, O_NONE, "abort");
        word(0, 0, 1, 1'b0, 1'b0, "abort_w0");
        step(0, 1'b0, 1'b0, 1'b0, O_READ, 1, "abort_w1_read");
        step(0, 1'b0, 1'b0, 1'b0, O_LOAD, 1, "abort_w1_load");
        step(0, 1'b1, 1'b0, 1'b0, O_CEN, 1, "abort_w1_cnt");
        step(0, 1'b0, 1'b0, 1'b0, O_NONE, 0, "abort_reset");
        start_batch(0, 1, 0, O_NONE, "restart");
        word(0, 0, 2, 1'b0, 1'b0, "restart_w0");
        word(0, 1, 2, 1'b0, 1'b0, "restart_w1");
        step(0, 1'b0, 1'b0, 1'b0, O_FIN, 1, "restart_fin");
        step(0, 1'b0, 1'b0, 1'b0, O_NONE, 1, "restart_idle");

`ifdef CONV_SEQ_TIMEOUT_EN
        // cnt_done never arrives: four COUNT cycles, then FIN with error set.
        start_batch(0, 1, 1, O_NONE, "wd");
        step(0, 1'b0, 1'b0, 1'b0, O_READ, 0, "wd_read");
        step(0, 1'b0, 1'b0, 1'b0, O_LOAD, 0, "wd_load");
        for (int i = 0; i < 4; i++)
            step(0, 1'b0, 1'b0, 1'b0, O_CEN, 0, "wd_cnt");
        step(0, 1'b0, 1'b0, 1'b0, O_FIN | O_ERR, 0, "wd_fin");
        step(0, 1'b0, 1'b0, 1'b0, O_ERR, 0, "wd_sticky");
        start_batch(0, 1, 0, O_ERR, "wd_restart");
        word(0, 0, 1, 1'b0, 1'b0, "wd_w0");
        word(0, 1, 1, 1'b0, 1'b0, "wd_w1");
        step(0, 1'b0, 1'b0, 1'b0, O_FIN, 1, "wd_restart_fin");
`else
        // Long stall: COUNT waits with en_c high and no error.
        start_batch(0, 1, 1, O_NONE, "stall");
        word(0, 0, 7, 1'b0, 1'b0, "stall_w0");
        word(0, 1, 1, 1'b0, 1'b0, "stall_w1");
        step(0, 1'b0, 1'b0, 1'b0, O_FIN, 1, "stall_fin");
`endif
        step(0, 1'b0, 1'b0, 1'b0, O_NONE, 1, "final_idle");

        // Single-item batch: WRITE goes straight to FIN, index stays 0.
        start_batch(1, 2, 0, O_NONE, "one");
        word(1, 0, 2, 1'b0, 1'b1, "one_w0");
        step(1, 1'b0, 1'b0, 1'b0, O_FIN, 0, "one_fin");
        step(1, 1'b0, 1'b0, 1'b0, O_NONE, 0, "one_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control FSM that sequences the number-conversion datapath across a batch of input words. On a start pulse it drives the datapath's read, load, count-enable, store and file-write strobes for each of `NUM_ITEMS` words in turn, then signals completion. It sits beside the datapath, sharing `clk`/`rst`, and is the only driver of the datapath's control inputs.

## Interface
- `NUM_ITEMS`, 8, words per batch (≥1)
- `MAX_CYCLES`, 32, count-phase timeout in cycles (used only with watchdog compiled in; ≥1)
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  batch request; accepted as a high-then-low pulse
- `cnt_done`  in  1  datapath reports conversion complete
- `read_data`  out  1  fetch next input word
- `ldn`  out  1  load fetched word into datapath
- `en_c`  out  1  counter enable
- `store_num`  out  1  latch converted result
- `write_to_file`  out  1  emit result
- `item_idx`  out  max(1,$clog2(NUM_ITEMS))  index of word in progress
- `busy`  out  1  batch in progress
- `done`  out  1  one-cycle batch-complete pulse
- `error`  out  1  sticky timeout flag

## Operation
- States: IDLE, ARMED, READ, LOAD, COUNT, STORE, WRITE, FIN.
- IDLE: `start`=1 → ARMED, else stay.
- ARMED: stay while `start`=1; `start`=0 → READ, clear `item_idx` and `error`.
- READ: `read_data`=1 → LOAD.
- LOAD: `ldn`=1 → COUNT.
- COUNT: `en_c` = ~`cnt_done` (Mealy); `cnt_done`=1 → STORE, else stay.
- STORE: `store_num`=1 → WRITE.
- WRITE: `write_to_file`=1; if `item_idx`==NUM_ITEMS-1 → FIN, else `item_idx`+1, → READ.
- FIN: `done`=1 → IDLE.
- `busy`=1 in READ..WRITE inclusive; 0 in IDLE, ARMED, FIN.
- All strobes except `en_c` are Moore decodes of the state register; at most one strobe high per cycle.
- `start` ignored outside IDLE/ARMED; no queuing of a second request.
- `item_idx` holds its final value after FIN until the next accepted start.

## Timing
- Reset: state IDLE; `read_data`, `ldn`, `en_c`, `store_num`, `write_to_file`, `busy`, `done`, `error` = 0; `item_idx` = 0. Reset mid-batch aborts immediately; next cycle is IDLE with all outputs reset.
- Start falling edge seen in cycle T → `read_data` high in T+1.
- Per word: 4 fixed cycles + K COUNT cycles, where K ≥ 1 includes the cycle `cnt_done` is sampled high. `en_c` high for K-1 cycles.
- Batch latency from READ entry to `done`: NUM_ITEMS·(4+K) + 0 cycles, with `done` the following cycle.
- `cnt_done` high on the first COUNT cycle → K=1, `en_c` never asserted for that word.
- `cnt_done` is ignored outside COUNT.
- NUM_ITEMS=1: WRITE goes straight to FIN; `item_idx` stays 0.

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined: a cycle counter runs in COUNT, cleared on COUNT entry. If MAX_CYCLES cycles elapse without `cnt_done`, set `error`=1 (sticky until next accepted start) and go COUNT → FIN, skipping STORE/WRITE and remaining words. `done` still pulses.
- Not defined: no counter; COUNT waits indefinitely; `error` tied 0.

## Structure
- Package `conv_seq_pkg`: state enum `conv_seq_state_t`, index-width helper function.
- Sub-module `conv_seq_watchdog`: timeout counter (clear, enable, expired), instantiated only under `CONV_SEQ_TIMEOUT_EN`.

## Test plan
- Reset held 3 cycles with `start`=1 → all outputs 0, state IDLE; `start` then low → no activity.
- NUM_ITEMS=2, `start` high 5 cycles then low, `cnt_done` high 3rd COUNT cycle → per word `read_data`,`ldn`, `en_c`×2, `store_num`,`write_to_file`; `done` pulses 14 cycles after READ entry; `item_idx` 0 then 1.
- `cnt_done` high on first COUNT cycle → `en_c` never high, word completes in 5 cycles.
- `rst` asserted during second word's COUNT → next cycle all outputs 0, `busy`=0; new start runs from `item_idx`=0.
- `start` pulsed while `busy` → ignored; batch length unchanged, single `done`.
- With `CONV_SEQ_TIMEOUT_EN`, MAX_CYCLES=4, `cnt_done` held 0 → after 4 COUNT cycles `error`=1, FIN, `done` pulse, no `store_num`; `error` clears on next accepted start.
